pattern_match_cfg_ctrl: RTL

Configuration sequencer and result collector for the 16-LUT CFGLUT5 80-bit pattern matcher. On request it latches an 80-bit mask/match pair, computes every LUT truth table on the fly, and shifts the 512 configuration bits into the CFGLUT5 chain over CDI/CE. It then reduces the LUT outputs into a single registered match flag that is qualified by configuration validity. It sits between the software-facing register block and the CFGLUT5 matcher array.

---
 rtl/pattern_match_cfg_ctrl_if.sv | 30 +++
 rtl/pattern_match_cfg_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/pattern_match_cfg_ctrl_if.sv
// Bus between the CFGLUT5 configuration sequencer and its environment:
// reconfiguration request, pattern inputs, CDI/CE chain drive, status and match result.
interface pattern_match_cfg_ctrl_if #(
    parameter int unsigned NUM_LUTS = 16
);
    localparam int unsigned PW = 5 * NUM_LUTS;

    logic                    cfg_start;
    logic [PW-1:0]           pattern_mask;
    logic [PW-1:0]           pattern_match;
    logic                    cfg_out;
    logic                    cfg_ce;
    logic                    cfg_busy;
    logic                    cfg_done;
    logic                    cfg_valid;
    logic [2*NUM_LUTS-1:0]   match_cfglut;
    logic                    match;

    // Environment side: software register block plus the LUT array
    modport master (
        output cfg_start, pattern_mask, pattern_match, match_cfglut,
        input  cfg_out, cfg_ce, cfg_busy, cfg_done, cfg_valid, match
    );

    // Sequencer side
    modport slave (
        input  cfg_start, pattern_mask, pattern_match, match_cfglut,
        output cfg_out, cfg_ce, cfg_busy, cfg_done, cfg_valid, match
    );
endinterface

// File: rtl/pattern_match_cfg_ctrl.sv
// Configuration sequencer and result collector for a chain of CFGLUT5s forming an
// 80-bit masked pattern matcher. Truth tables are generated bit by bit during the shift.
module pattern_match_cfg_ctrl #(
    parameter int unsigned NUM_LUTS = 16
) (
    input logic                    clk,
    input logic                    reset,
    pattern_match_cfg_ctrl_if.slave bus
);
    localparam int unsigned PW    = 5 * NUM_LUTS;
    localparam int unsigned NBITS = 32 * NUM_LUTS;
    localparam int unsigned KW    = $clog2(NBITS);
    localparam logic [KW-1:0] KLast = KW'(NBITS - 1);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StShift = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [PW-1:0] mask_q, mask_d;
    logic [PW-1:0] pmatch_q, pmatch_d;
    logic          cfg_out_q, cfg_out_d;
    logic          cfg_ce_q, cfg_ce_d;
    logic          cfg_done_q, cfg_done_d;
    logic          cfg_valid_q, cfg_valid_d;
    logic          match_q, match_d;
    logic          start_acc;
    logic [KW-1:0] k_inc;

    logic [NUM_LUTS-1:0] o6;
    logic [NUM_LUTS-1:0] unused_o5;

    // Bit k of the chain stream: first bit lands in the last LUT's INIT[31].
    function automatic logic lut_bit(input logic [PW-1:0] m, input logic [PW-1:0] p,
                                     input logic [KW-1:0] k);
        int unsigned lut;
        logic [4:0]  addr;
        logic [4:0]  ms;
        logic [4:0]  ps;
        lut  = NUM_LUTS - 1 - (32'(k) >> 5);
        addr = ~k[4:0];  // 31 - (k mod 32)
        ms   = 5'(m >> (5 * lut));
        ps   = 5'(p >> (5 * lut));
        return ((addr & ms) == ps);
    endfunction

    // Split LUT outputs; only O6 contributes to the result
    always_comb begin
        o6        = '0;
        unused_o5 = '0;
        for (int i = 0; i < int'(NUM_LUTS); i++) begin
            o6[i]        = bus.match_cfglut[2*i];
            unused_o5[i] = bus.match_cfglut[2*i+1];
        end
    end

    // Next-state: accept a load in idle, stream one configuration bit per cycle in shift
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        mask_d      = mask_q;
        pmatch_d    = pmatch_q;
        cfg_out_d   = 1'b0;
        cfg_ce_d    = 1'b0;
        cfg_done_d  = 1'b0;
        cfg_valid_d = cfg_valid_q;
        start_acc   = 1'b0;
        k_inc       = k_q + 1'b1;
        case (state_q)
            StIdle: begin
                if (bus.cfg_start) begin
                    start_acc   = 1'b1;
                    state_d     = StShift;
                    k_d         = '0;
                    mask_d      = bus.pattern_mask;
                    pmatch_d    = bus.pattern_match;
                    cfg_valid_d = 1'b0;
                    cfg_ce_d    = 1'b1;
                    // Bit 0 comes straight from the inputs so it is ready right after acceptance
                    cfg_out_d   = lut_bit(bus.pattern_mask, bus.pattern_match, '0);
                end
            end
            StShift: begin
                if (k_q == KLast) begin
                    state_d     = StIdle;
                    cfg_valid_d = 1'b1;
                    cfg_done_d  = 1'b1;
                end else begin
                    k_d       = k_inc;
                    cfg_ce_d  = 1'b1;
                    cfg_out_d = lut_bit(mask_q, pmatch_q, k_inc);
                end
            end
            default: state_d = StIdle;
        endcase
        // Compare only against a completed configuration; blank on a new load
        match_d = cfg_valid_q & ~start_acc & (&o6);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            k_q         <= '0;
            mask_q      <= '0;
            pmatch_q    <= '0;
            cfg_out_q   <= 1'b0;
            cfg_ce_q    <= 1'b0;
            cfg_done_q  <= 1'b0;
            cfg_valid_q <= 1'b0;
            match_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            mask_q      <= mask_d;
            pmatch_q    <= pmatch_d;
            cfg_out_q   <= cfg_out_d;
            cfg_ce_q    <= cfg_ce_d;
            cfg_done_q  <= cfg_done_d;
            cfg_valid_q <= cfg_valid_d;
            match_q     <= match_d;
        end
    end

    assign bus.cfg_out   = cfg_out_q;
    assign bus.cfg_ce    = cfg_ce_q;
    assign bus.cfg_busy  = (state_q == StShift);
    assign bus.cfg_done  = cfg_done_q;
    assign bus.cfg_valid = cfg_valid_q;
    assign bus.match     = match_q;
endmodule
